// File: rtl/wb_calram_reader_pkg.sv
// Shared types and address layout for the calibration-RAM WISHBONE reader.
package wb_calram_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCtrlWr,
    StGap,
    StRd,
    StHold,
    StNext,
    StDone
  } state_e;

  localparam int unsigned AdrW       = 19;
  localparam int unsigned ChunkW     = 5;
  localparam int unsigned WordFieldW = 12;
  localparam int unsigned ChunkLsb   = 14;
  localparam int unsigned WordLsb    = 2;

  localparam int unsigned CtrlChunk = 24;
  localparam logic [WordFieldW-1:0] CtrlRegEnable = 12'd0;
  localparam logic [WordFieldW-1:0] CtrlRegMode   = 12'd1;
  localparam logic [WordFieldW-1:0] CtrlRegRoll   = 12'd2;

  // Byte address = {chunk, word, 2'b00}.
  function automatic logic [AdrW-1:0] calram_adr(input logic [ChunkW-1:0]     chunk,
                                                 input logic [WordFieldW-1:0] word);
    return {chunk, word, 2'b00};
  endfunction

endpackage

// File: rtl/calram_rd_skid.sv
// Single-entry output register: captures one read word and holds it until the stream accepts it.
module calram_rd_skid
  import wb_calram_reader_pkg::*;
#(
  parameter int unsigned DataW = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DataW-1:0]  dat_i,
  input  logic [ChunkW-1:0] lab_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DataW-1:0]  dat_o,
  output logic [ChunkW-1:0] lab_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DataW-1:0]  dat_q;
  logic [ChunkW-1:0] lab_q;
  logic              last_q;

  always_comb begin
    valid_d = valid_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i)             valid_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      dat_q   <= '0;
      lab_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        dat_q  <= dat_i;
        lab_q  <= lab_i;
        last_q <= last_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign dat_o   = dat_q;
  assign lab_o   = lab_q;
  assign last_o  = last_q;

endmodule

// File: rtl/wb_calram_reader.sv
// WISHBONE master that drains selected LAB chunks of the calibration RAM onto a valid/ready stream.
module wb_calram_reader
  import wb_calram_reader_pkg::*;
#(
  parameter int unsigned NUM_LABS      = 24,
  parameter int unsigned WORDS_PER_LAB = 4096,
  parameter int unsigned CTRL_CHUNK    = CtrlChunk,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [NUM_LABS-1:0] lab_mask_i,
  input  logic                disable_first_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [AdrW-1:0]     wb_adr_o,
  output logic [31:0]         wb_dat_o,
  output logic [3:0]          wb_sel_o,
  input  logic [31:0]         wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_rty_i,
  output logic [31:0]         m_dat_o,
  output logic [ChunkW-1:0]   m_lab_o,
  output logic                m_last_o,
  output logic                m_valid_o,
  input  logic                m_ready_i
);

  localparam int unsigned WordW = (WORDS_PER_LAB > 1) ? $clog2(WORDS_PER_LAB) : 1;
  localparam logic [WordW-1:0] LastWord = WordW'(WORDS_PER_LAB - 1);
  localparam logic [7:0]       TmoLast  = 8'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [NUM_LABS-1:0] mask_q, mask_d;
  logic [ChunkW-1:0]   lab_q, lab_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [7:0]          tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                gap_rd_q, gap_rd_d;

  logic                load;
  logic                nxt_found;
  logic [ChunkW-1:0]   nxt_lab;
  logic                bus_fail;

  // Lowest pending LAB at or above the pointer; finished LABs have their mask bit cleared.
  always_comb begin
    nxt_found = 1'b0;
    nxt_lab   = '0;
    for (int i = NUM_LABS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(lab_q))) begin
        nxt_found = 1'b1;
        nxt_lab   = ChunkW'(i);
      end
    end
  end

  assign bus_fail = wb_err_i || wb_rty_i || (tmo_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    lab_d    = lab_q;
    word_d   = word_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    gap_rd_d = gap_rd_q;
    load     = 1'b0;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    done_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d  = 1'b0;
          mask_d = lab_mask_i;
          lab_d  = '0;
          word_d = '0;
          tmo_d  = '0;
          if (lab_mask_i == '0)    state_d = StDone;
          else if (disable_first_i) state_d = StCtrlWr;
          else                      state_d = StNext;
        end
      end
      StCtrlWr: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = calram_adr(ChunkW'(CTRL_CHUNK), CtrlRegEnable);
        if (wb_ack_i) begin
          tmo_d    = '0;
          gap_rd_d = 1'b0;
          state_d  = StGap;
        end else if (bus_fail) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      // Registered slave ack trails stb by a cycle; this idle cycle keeps it from being reused.
      StGap: state_d = gap_rd_q ? StRd : StNext;
      StNext: begin
        if (nxt_found) begin
          lab_d   = nxt_lab;
          word_d  = '0;
          state_d = StRd;
        end else begin
          state_d = StDone;
        end
      end
      StRd: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = calram_adr(lab_q, WordFieldW'(word_q));
        if (wb_ack_i) begin
          tmo_d   = '0;
          load    = 1'b1;
          state_d = StHold;
        end else if (bus_fail) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StHold: begin
        if (m_valid_o && m_ready_i) begin
          if (word_q == LastWord) begin
            mask_d[lab_q] = 1'b0;
            gap_rd_d      = 1'b0;
          end else begin
            word_d   = word_q + WordW'(1);
            gap_rd_d = 1'b1;
          end
          state_d = StGap;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      lab_q    <= '0;
      word_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      gap_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      lab_q    <= lab_d;
      word_q   <= word_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      gap_rd_q <= gap_rd_d;
    end
  end

  assign busy_o   = (state_q != StIdle) && (state_q != StDone);
  assign err_o    = err_q;
  assign wb_dat_o = '0;
  assign wb_sel_o = 4'hF;

  calram_rd_skid #(
    .DataW (32)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .dat_i   (wb_dat_i),
    .lab_i   (lab_q),
    .last_i  (word_q == LastWord),
    .ready_i (m_ready_i),
    .valid_o (m_valid_o),
    .dat_o   (m_dat_o),
    .lab_o   (m_lab_o),
    .last_o  (m_last_o)
  );

endmodule

// File: tb/tb_wb_calram_reader.sv
// Bench: a full-size reader (index 0) and a 16-word build (index 1) against a modelled calram slave.
module tb_wb_calram_reader;

  localparam int AckTmo = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic        rst     [2];
  logic        start   [2];
  logic [23:0] mask    [2];
  logic        dis     [2];
  logic        busy    [2];
  logic        done    [2];
  logic        err     [2];
  logic        cyc     [2];
  logic        stb     [2];
  logic        we      [2];
  logic [18:0] adr     [2];
  logic [31:0] wdat    [2];
  logic [3:0]  sel     [2];
  logic [31:0] rdat    [2];
  logic        ack     [2] = '{1'b0, 1'b0};
  logic        werr    [2];
  logic        rty     [2];
  logic [31:0] mdat    [2];
  logic [4:0]  mlab    [2];
  logic        mlast   [2];
  logic        mvalid  [2];
  logic        ready   [2] = '{1'b1, 1'b1};
  logic        rdy_rnd [2] = '{1'b0, 1'b0};
  logic        hold_en [2] = '{1'b0, 1'b0};
  logic [14:0] key;

  wb_calram_reader u_dut (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .lab_mask_i(mask[0]),
    .disable_first_i(dis[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
    .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(we[0]), .wb_adr_o(adr[0]),
    .wb_dat_o(wdat[0]), .wb_sel_o(sel[0]), .wb_dat_i(rdat[0]), .wb_ack_i(ack[0]),
    .wb_err_i(werr[0]), .wb_rty_i(rty[0]), .m_dat_o(mdat[0]), .m_lab_o(mlab[0]),
    .m_last_o(mlast[0]), .m_valid_o(mvalid[0]), .m_ready_i(ready[0])
  );

  wb_calram_reader #(.WORDS_PER_LAB(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .lab_mask_i(mask[1]),
    .disable_first_i(dis[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
    .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(we[1]), .wb_adr_o(adr[1]),
    .wb_dat_o(wdat[1]), .wb_sel_o(sel[1]), .wb_dat_i(rdat[1]), .wb_ack_i(ack[1]),
    .wb_err_i(werr[1]), .wb_rty_i(rty[1]), .m_dat_o(mdat[1]), .m_lab_o(mlab[1]),
    .m_last_o(mlast[1]), .m_valid_o(mvalid[1]), .m_ready_i(ready[1])
  );

  // Slave: registered single-cycle ack; RAM word = {key, chunk, word}. Word 7 can be made to hang.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ack[i]  <= cyc[i] && stb[i] && !ack[i] && !(hold_en[i] && adr[i][13:2] == 12'd7);
      rdat[i] <= {key, adr[i][18:2]};
    end
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) ready[i] = rdy_rnd[i] ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  // Observed traffic, sampled mid-cycle.
  logic [37:0] strm [2][$];
  logic [51:0] ops  [2][$];
  int   cyc_cnt [2]     = '{0, 0};
  int   done_cnt [2]    = '{0, 0};
  int   viol_hold [2]   = '{0, 0};
  int   viol_gap [2]    = '{0, 0};
  int   viol_stable [2] = '{0, 0};
  int   run [2]         = '{0, 0};
  int   last_run [2]    = '{0, 0};
  logic stb_prev [2]    = '{1'b0, 1'b0};
  logic acc_prev [2]    = '{1'b0, 1'b0};
  logic held_prev [2]   = '{1'b0, 1'b0};
  logic [37:0] pay_prev [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i] && ready[i]) strm[i].push_back({mlab[i], mlast[i], mdat[i]});
      if (cyc[i] && stb[i] && !stb_prev[i]) ops[i].push_back({we[i], adr[i], wdat[i]});
      if (stb[i] && mvalid[i]) viol_hold[i]++;
      if (stb[i] && acc_prev[i]) viol_gap[i]++;
      if (held_prev[i] && mvalid[i] && pay_prev[i] !== {mlab[i], mlast[i], mdat[i]})
        viol_stable[i]++;
      if (cyc[i]) cyc_cnt[i]++;
      if (done[i]) done_cnt[i]++;
      if (stb[i]) run[i]++;
      else begin
        if (run[i] != 0) last_run[i] = run[i];
        run[i] = 0;
      end
      acc_prev[i]  = stb[i] && ack[i];
      stb_prev[i]  = stb[i];
      held_prev[i] = mvalid[i] && !ready[i];
      pay_prev[i]  = {mlab[i], mlast[i], mdat[i]};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: every selected LAB in ascending order, words 0..words-1, last on the final word.
  task automatic check_stream(input string tag, input int i, input int from,
                              input logic [23:0] m, input int words, input int limit);
    int j = from;
    int bad = 0;
    int first = -1;
    for (int lab = 0; lab < 24; lab++) begin
      if (m[lab]) begin
        for (int w = 0; w < words; w++) begin
          if (j - from < limit) begin
            logic [37:0] e;
            e = {5'(lab), (w == words - 1), key, 5'(lab), 12'(w)};
            if (j >= strm[i].size() || strm[i][j] !== e) begin
              bad++;
              if (first < 0) first = j - from;
            end
            j++;
          end
        end
      end
    end
    check({tag, "_count"}, strm[i].size() - from, j - from);
    check({tag, "_bad_words"}, bad, 0);
  endtask

  task automatic kick(input int i, input logic [23:0] m, input logic d);
    @(negedge clk);
    mask[i]  = m;
    dis[i]   = d;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int n = 0;
    while (!done[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, (n < budget), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, o0, d0, c0, h0, g0, t0, n, lasts;
    logic [18:0] a23;
    logic [23:0] m;

    key = 15'($urandom);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0; mask[i] = '0; dis[i] = 1'b0;
      werr[i] = 1'b0; rty[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_cyc", i), cyc[i], 0);
      check($sformatf("rst%0d_stb", i), stb[i], 0);
      check($sformatf("rst%0d_busy", i), busy[i], 0);
      check($sformatf("rst%0d_done", i), done[i], 0);
      check($sformatf("rst%0d_err", i), err[i], 0);
      check($sformatf("rst%0d_valid", i), mvalid[i], 0);
      check($sformatf("rst%0d_adr", i), adr[i], 0);
      check($sformatf("rst%0d_sel", i), sel[i], 4'hF);
    end
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    // Full LAB 0, always ready.
    s0 = strm[0].size(); o0 = ops[0].size(); d0 = done_cnt[0];
    h0 = viol_hold[0]; g0 = viol_gap[0];
    kick(0, 24'h000001, 1'b0);
    wait_done(0, 20000, "lab0");
    check_stream("lab0", 0, s0, 24'h000001, 4096, 4096);
    check("lab0_reads", ops[0].size() - o0, 4096);
    check("lab0_first_adr", ops[0][o0][50:32], 19'h00000);
    check("lab0_last_adr", ops[0][ops[0].size() - 1][50:32], 19'h03FFC);
    check("lab0_done_pulses", done_cnt[0] - d0, 1);
    check("lab0_err", err[0], 0);
    check("lab0_busy_after", busy[0], 0);
    check("lab0_hold_viol", viol_hold[0] - h0, 0);
    check("lab0_gap_viol", viol_gap[0] - g0, 0);

    // Disable-first write, then LABs 0, 2, 23 on the 16-word build.
    s0 = strm[1].size(); o0 = ops[1].size();
    kick(1, 24'h800005, 1'b1);
    wait_done(1, 3000, "multi");
    check("multi_first_op", ops[1][o0], {1'b1, 19'h60000, 32'h0});
    a23 = '1;
    for (int k = o0; k < ops[1].size(); k++)
      if (ops[1][k][50:46] == 5'd23 && a23 == '1) a23 = ops[1][k][50:32];
    check("multi_lab23_first_adr", a23, 19'h5C000);
    check_stream("multi", 1, s0, 24'h800005, 16, 48);
    lasts = 0;
    for (int k = s0; k < strm[1].size(); k++) if (strm[1][k][32]) lasts++;
    check("multi_last_pulses", lasts, 3);
    check("multi_err", err[1], 0);

    // Empty mask: done almost immediately, no bus cycle.
    c0 = cyc_cnt[0]; d0 = done_cnt[0];
    kick(0, 24'h000000, 1'b0);
    wait_done(0, 2, "empty");
    check("empty_no_cyc", cyc_cnt[0] - c0, 0);
    check("empty_done_pulses", done_cnt[0] - d0, 1);

    // Random LAB selection with a throttled consumer.
    for (int r = 0; r < 2; r++) begin
      m = 24'd0;
      for (int b = 0; b < 3; b++) m[$urandom_range(0, 23)] = 1'b1;
      s0 = strm[1].size(); h0 = viol_hold[1]; g0 = viol_gap[1]; t0 = viol_stable[1];
      rdy_rnd[1] = 1'b1;
      kick(1, m, 1'(r));
      wait_done(1, 5000, $sformatf("thr%0d", r));
      rdy_rnd[1] = 1'b0;
      check_stream($sformatf("thr%0d", r), 1, s0, m, 16, 48);
      check($sformatf("thr%0d_hold_viol", r), viol_hold[1] - h0, 0);
      check($sformatf("thr%0d_gap_viol", r), viol_gap[1] - g0, 0);
      check($sformatf("thr%0d_stable_viol", r), viol_stable[1] - t0, 0);
    end

    // Ack withheld on word 7: timeout, seven words streamed, error raised.
    s0 = strm[0].size(); d0 = done_cnt[0];
    hold_en[0] = 1'b1;
    kick(0, 24'h000001, 1'b0);
    wait_done(0, 2000, "tmo");
    hold_en[0] = 1'b0;
    check("tmo_err", err[0], 1);
    check("tmo_stb_cycles", last_run[0], AckTmo);
    check("tmo_stb_low", stb[0], 0);
    check("tmo_done_pulses", done_cnt[0] - d0, 1);
    check_stream("tmo", 0, s0, 24'h000001, 4096, 7);
    kick(0, 24'h000000, 1'b0);
    check("tmo_err_cleared", err[0], 0);
    wait_done(0, 4, "tmo_clear");

    // Reset while word 100 is on the bus, then a fresh run starts from word 0.
    kick(0, 24'h000001, 1'b0);
    n = 0;
    while (!(stb[0] && adr[0][13:2] == 12'd100) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reached_word100", (n < 1000), 1);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_cyc", cyc[0], 0);
    check("rstmid_valid", mvalid[0], 0);
    check("rstmid_busy", busy[0], 0);
    @(negedge clk);
    rst[0] = 1'b1;
    s0 = strm[0].size(); o0 = ops[0].size();
    kick(0, 24'h000001, 1'b0);
    n = 0;
    while (strm[0].size() <= s0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rstmid_restart_adr", (ops[0].size() > o0) ? ops[0][o0][50:32] : 19'h7FFFF, 19'h0);
    check("rstmid_restart_word", (strm[0].size() > s0) ? strm[0][s0] : '1,
          {5'd0, 1'b0, key, 17'd0});
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
